// File: rtl/instr_decode_queue_if.sv
// instr_decode_queue_if: fetch-side and decode-side handshake bundle for instr_decode_queue.
interface instr_decode_queue_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_instr;
  logic [XLEN-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_instr;
  logic [XLEN-1:0]        out_pc;
  logic                   out_legal;
  logic [$clog2(DEPTH):0] count;
  modport master (output in_valid, in_instr, in_pc, out_ready,
                  input  in_ready, out_valid, out_instr, out_pc, out_legal, count);
  modport slave  (input  in_valid, in_instr, in_pc, out_ready,
                  output in_ready, out_valid, out_instr, out_pc, out_legal, count);
endinterface

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: fetch-to-decode FIFO that tags each opcode legal/illegal at enqueue.
// Define IQ_BYPASS_EN to let an empty queue pass the fetch entry straight to decode.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  instr_decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [XLEN-1:0]  instr_d [DEPTH];
  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [XLEN-1:0]  pc_d [DEPTH];
  logic [DEPTH-1:0] legal_q, legal_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, head_valid, byp, in_legal, push, pop;
  always_comb begin
    empty      = count_q == '0;
    full       = count_q == CW'(DEPTH);
    head_valid = reset && !empty && !flush;
`ifdef IQ_BYPASS_EN
    byp        = reset && empty && !flush;
`else
    byp        = 1'b0;
`endif
    in_legal   = q.in_instr[6:0] inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                                         7'b1101111, 7'b0110011, 7'b0010111, 7'b1100111};
    q.in_ready  = reset && !full && !flush;
    q.out_valid = byp ? q.in_valid : head_valid;
    q.out_instr = !q.out_valid ? '0 : byp ? q.in_instr : instr_q[rd_ptr_q];
    q.out_pc    = !q.out_valid ? '0 : byp ? q.in_pc : pc_q[rd_ptr_q];
    q.out_legal = q.out_valid && (byp ? in_legal : legal_q[rd_ptr_q]);
    q.count     = count_q;
    // a bypassed entry consumed this cycle never occupies a slot
    push     = q.in_valid && q.in_ready && !(byp && q.out_ready);
    pop      = head_valid && q.out_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    instr_d  = instr_q;
    pc_d     = pc_q;
    legal_d  = legal_q;
    if (push) begin
      instr_d[wr_ptr_q] = q.in_instr;
      pc_d[wr_ptr_q]    = q.in_pc;
      legal_d[wr_ptr_q] = in_legal;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
    legal_q <= legal_d;
  end
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed self-checking bench for instr_decode_queue.
module tb_instr_decode_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] tbl [4] = '{32'h00500093, 32'h00A00113, 32'h123450B7, 32'h0000006F};
  instr_decode_queue_if #(.XLEN(32), .DEPTH(4)) bus ();
  instr_decode_queue #(.DEPTH(4), .XLEN(32)) dut (.clk(clk), .reset(reset), .flush(flush), .q(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask
  function automatic logic [31:0] a_ins(input int k);
    return 32'h00000013 | (32'(k) << 20);
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);
    chk("idle_out_instr", bus.out_instr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = tbl[i];
      bus.in_pc = 32'(4 * i);
      #1;
      chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_head", bus.out_instr, tbl[0]);
    end
    bus.in_instr = 32'hDEADBEEF;
    bus.in_pc = 32'h0000_0FF0;
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("full_stall_count", 32'(bus.count), 32'd4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_instr", bus.out_instr, tbl[i]);
      chk("drain_pc", bus.out_pc, 32'(4 * i));
      chk("drain_legal", 32'(bus.out_legal), 32'd1);
      tick();
      chk("drain_count", 32'(bus.count), 32'(3 - i));
    end
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_instr", bus.out_instr, 32'd0);
    tick();
    chk("empty_pop_count", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (k < 8);
      bus.in_instr = a_ins(k);
      bus.in_pc = 32'h100 + 32'(4 * k);
      bus.out_ready = (k >= 2);
      #1;
      if (k >= 2) begin
        chk("conc_instr", bus.out_instr, a_ins(k - 2));
        chk("conc_pc", bus.out_pc, 32'h100 + 32'(4 * (k - 2)));
      end
      tick();
      chk("conc_count", 32'(bus.count), k < 2 ? 32'(k + 1) : k < 8 ? 32'd2 : 32'(9 - k));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    push(32'hFFFFFFFF, 32'h40);
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_legal", 32'(bus.out_legal), 32'd0);
    chk("ill_pc", bus.out_pc, 32'h40);
    chk("ill_instr", bus.out_instr, 32'hFFFFFFFF);
    bus.out_ready = 1'b1;
    tick();
    chk("ill_pop_count", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(tbl[i], 32'h60 + 32'(4 * i));
    chk("preflush_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00000033;
    bus.in_pc = 32'h70;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("postflush_count", 32'(bus.count), 32'd0);
    chk("postflush_valid", 32'(bus.out_valid), 32'd0);
    push(32'h00000033, 32'h80);
    chk("postflush_head", bus.out_instr, 32'h00000033);
    chk("postflush_pc", bus.out_pc, 32'h80);
    chk("postflush_cnt1", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(a_ins(20 + i), 32'h90 + 32'(4 * i));
    bus.out_ready = 1'b1;
    tick();
    chk("middrain_count", 32'(bus.count), 32'd2);
    chk("middrain_head", bus.out_instr, a_ins(21));
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_count", 32'(bus.count), 32'd0);
    chk("rel_instr", bus.out_instr, 32'd0);
    push(32'h00000017, 32'hA0);
    chk("rel_head", bus.out_instr, 32'h00000017);
    chk("rel_legal", 32'(bus.out_legal), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("rel_pop_count", 32'(bus.count), 32'd0);
`ifdef IQ_BYPASS_EN
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00000013;
    bus.in_pc = 32'h200;
    #1;
    chk("byp_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_instr", bus.out_instr, 32'h00000013);
    chk("byp_pc", bus.out_pc, 32'h200);
    tick();
    chk("byp_count", 32'(bus.count), 32'd0);
    bus.in_valid = 1'b0;
`endif
    bus.out_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Small instruction queue between the fetch side and the decode/immediate-generation stage of each core.
- Buffers fetched {instruction, PC} pairs with valid/ready handshakes on both sides.
- Classifies each opcode as supported or illegal at enqueue, so decode and the immediate generator always see a stable instruction.
- Supports a single-cycle flush for branch/jump redirects.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of instruction and PC fields.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous queue clear (redirect).
- in_valid, input, 1, fetch side presents an entry.
- in_ready, output, 1, queue can accept an entry.
- in_instr, input, XLEN, fetched instruction word.
- in_pc, input, XLEN, PC of in_instr.
- out_valid, output, 1, head entry available to decode.
- out_ready, input, 1, decode consumes head this cycle.
- out_instr, output, XLEN, head instruction.
- out_pc, output, XLEN, head PC.
- out_legal, output, 1, head opcode is in the supported set.
- count, output, $clog2(DEPTH)+1, current occupancy.

Behaviour:
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH, plus separate count register (full = count==DEPTH, empty = count==0).
- Reset (reset low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - in_ready = 0 while reset is low; it goes to 1 on the first cycle after release.
  - out_valid = 0; out_instr, out_pc and out_legal = 0.
  - Entry storage is not reset.
- Push: occurs when in_valid && in_ready.
  - Stores {in_instr, in_pc, legal}, wr_ptr++, count++.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr++, count--.
- Output timing:
  - in_ready = !full && !flush. It is registered-state based and has no combinational path from out_ready, so a full queue does not accept in a pop cycle.
  - out_valid = !empty && !flush.
  - out_instr, out_pc and out_legal come combinationally from the entry at rd_ptr.
  - All three are driven 0 whenever out_valid = 0.
- Latency: entry pushed at cycle N is presented at cycle N+1 at the earliest.
- Simultaneous push and pop: both pointers advance, count unchanged. Legal at any non-full, non-empty occupancy, and when full only the pop occurs.
- Flush:
  - At the next edge, pointers and count = 0.
  - No push or pop handshake completes in the flush cycle: in_ready = 0 and out_valid = 0 that cycle.
  - Flush while reset is low has no effect.
- Legality (computed on in_instr[6:0] at push): legal = 1 for opcodes 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 0110011, 0010111, 1100111; otherwise 0. Illegal entries are still queued and delivered in order.
- Boundary conditions:
  - in_valid while full: held off, no overwrite.
  - out_ready while empty: ignored, count stays 0.
  - in_instr/in_pc may change while in_valid = 1 and in_ready = 0; only the value at the handshake edge is stored.
- Ordering: strict FIFO; no reordering, no drops except by flush or reset.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- When defined, and count==0 and !flush:
  - out_valid = in_valid; out_instr, out_pc and out_legal are driven combinationally from the in_* inputs.
  - If out_ready is also 1, the entry is consumed in the same cycle and not written (pointers and count unchanged).
  - If out_ready is 0, a normal push occurs.
- Not defined: no combinational in-to-out path; minimum latency 1 cycle as above.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release.
  - Required: in_ready=1, out_valid=0, count=0, out_instr=0.
- Fill and drain, out_ready=0: push instrs 0x00500093, 0x00A00113, 0x123450B7, 0x0000006F at PCs 0x0,0x4,0x8,0xC.
  - Required: count 1..4, in_ready=0 at count=4, a 5th push stalls.
  - Then out_ready=1 drains four entries in order with matching PCs, out_legal=1 each, count back to 0.
- Concurrent push/pop at count=2 for 6 cycles.
  - Required: count remains 2, outputs in FIFO order across pointer wrap (rd_ptr passes 3→0).
- Illegal opcode: push 0xFFFFFFFF at PC 0x40.
  - Required: delivered with out_legal=0 and out_pc=0x40.
- Flush with 3 entries and in_valid=1 in same cycle.
  - Required: in_ready=0 and out_valid=0 that cycle, no entry stored; next cycle count=0, out_valid=0.
- Reset asserted mid-drain at count=2.
  - Required: out_valid=0 and count=0 immediately (asynchronous), no stale entry after release.
  - With IQ_BYPASS_EN: push 0x00000013 to an empty queue with out_ready=1; required out_valid=1 in that same cycle and count stays 0.
